// File: rtl/xor_parity_stream.sv
// Streaming packet parity engine: stage 1 registers each word's XOR reduction,
// stage 2 folds words into a per-packet parity and saturating word count.
module xor_parity_stream #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_parity,
   output logic [CNT_W-1:0] out_count,
   output logic             out_sat
);

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e           state_q, state_d;
   logic             v1_q, v1_d;
   logic             p1_q, p1_d;
   logic             last1_q, last1_d;
   logic             acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic             out_parity_q, out_parity_d;
   logic [CNT_W-1:0] out_count_q, out_count_d;
   logic             out_sat_q, out_sat_d;

   logic             adv1;
   logic             accept;
   logic             fold_acc;
   logic [CNT_W-1:0] fold_cnt;

   // Only a last word facing an occupied, unconsumed result blocks stage 1.
   assign adv1     = !(v1_q && last1_q && out_valid_q && !out_ready);
   assign in_ready = !v1_q || adv1;
   assign accept   = in_valid && in_ready;

   // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      v1_d    = v1_q;
      p1_d    = p1_q;
      last1_d = last1_q;
      if (adv1) begin
         v1_d = accept;
      end
      if (accept) begin
         p1_d    = ^in_data;
         last1_d = in_last;
      end
   end

   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      out_valid_d  = out_valid_q && !out_ready;
      out_parity_d = out_parity_q;
      out_count_d  = out_count_q;
      out_sat_d    = out_sat_q;

      fold_acc = ((state_q == IDLE) ? 1'b0 : acc_q) ^ p1_q;
      if (state_q == IDLE) begin
         fold_cnt = CNT_W'(1);
      end else if (cnt_q == CNT_MAX) begin
         fold_cnt = cnt_q;
      end else begin
         fold_cnt = cnt_q + CNT_W'(1);
      end

      if (v1_q && adv1) begin
         acc_d = fold_acc;
         cnt_d = fold_cnt;
         if (last1_q) begin
            // A load here can coincide with the handoff of the previous result.
            state_d      = IDLE;
            out_valid_d  = 1'b1;
            out_parity_d = fold_acc;
            out_count_d  = fold_cnt;
            out_sat_d    = (fold_cnt == CNT_MAX);
         end else begin
            state_d = ACTIVE;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         v1_q         <= 1'b0;
         p1_q         <= 1'b0;
         last1_q      <= 1'b0;
         acc_q        <= 1'b0;
         cnt_q        <= '0;
         out_valid_q  <= 1'b0;
         out_parity_q <= 1'b0;
         out_count_q  <= '0;
         out_sat_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         v1_q         <= v1_d;
         p1_q         <= p1_d;
         last1_q      <= last1_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         out_valid_q  <= out_valid_d;
         out_parity_q <= out_parity_d;
         out_count_q  <= out_count_d;
         out_sat_q    <= out_sat_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_parity = out_parity_q;
   assign out_count  = out_count_q;
   assign out_sat    = out_sat_q;

endmodule

// File: tb/tb_xor_parity_stream.sv
// Self-checking bench for xor_parity_stream: a packet-level reference model
// (running parity, saturating count, queue of results) plus directed literal cases.
module tb_xor_parity_stream;

   localparam int WIDTH   = 32;
   localparam int CNT_W   = 16;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam int NPKT    = 10000;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic             out_parity;
   logic [CNT_W-1:0] out_count;
   logic             out_sat;

   logic             in_ready4;
   logic             out_valid4;
   logic             out_parity4;
   logic [3:0]       out_count4;
   logic             out_sat4;

   logic             rand_mode   = 1'b0;
   logic             ready_force = 1'b1;

   always #5 clk = ~clk;

   xor_parity_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_parity(out_parity), .out_count(out_count), .out_sat(out_sat)
   );

   xor_parity_stream #(.WIDTH(WIDTH), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid4), .out_ready(out_ready),
      .out_parity(out_parity4), .out_count(out_count4), .out_sat(out_sat4)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: results expected but not yet handed off, plus the partial packet.
   typedef struct packed {
      logic             parity;
      logic [CNT_W-1:0] count;
      logic             sat;
   } res_t;

   typedef struct {
      logic             parity;
      logic [CNT_W-1:0] count;
      logic             sat;
      int               cyc;
   } log_t;

   res_t       exp_q[$];
   log_t       log_q[$];
   logic [5:0] log4_q[$];
   logic       m_par = 1'b0;
   int         m_cnt = 0;
   res_t       m_res;
   int         cyc = 0;
   int         last_acc_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Everything is sampled mid-cycle; the handshakes seen here are the ones the next edge takes.
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         m_par = 1'b0;
         m_cnt = 0;
      end else begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_result: got parity %0b count %0d, none expected",
                        out_parity, out_count);
            end else begin
               check("model_result", {14'd0, out_parity, out_count, out_sat}, {14'd0, exp_q[0]});
            end
            if (out_ready) begin
               log_q.push_back('{out_parity, out_count, out_sat, cyc});
               if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
         end
         if (out_valid4 && out_ready) log4_q.push_back({out_parity4, out_count4, out_sat4});
         if (in_valid && in_ready) begin
            m_par = m_par ^ (^in_data);
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            if (in_last) begin
               m_res.parity = m_par;
               m_res.count  = CNT_W'(m_cnt);
               m_res.sat    = (m_cnt == CNT_MAX);
               exp_q.push_back(m_res);
               last_acc_cyc = cyc;
               m_par = 1'b0;
               m_cnt = 0;
            end
         end
      end
   end

   always @(posedge clk) begin
      #2;
      out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : ready_force;
   end

   task automatic idle();
      in_valid = 1'b0;
      in_data  = $urandom;
      in_last  = 1'($urandom);
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [WIDTH-1:0] d, input logic l);
      logic took;
      int   guard;
      took  = 1'b0;
      guard = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!took && guard < 200) begin
         @(negedge clk);
         took = in_ready;
         @(posedge clk);
         #1;
         guard++;
      end
      if (!took) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: word %0h never accepted within %0d cycles", d, guard);
      end
      in_valid = 1'b0;
      in_data  = $urandom;
      in_last  = 1'($urandom);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      int n4;
      int len;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_parity", out_parity, 0);
      check("rst_out_count", out_count, 0);
      check("rst_out_sat", out_sat, 0);
      check("rst_out_valid4", out_valid4, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("in_ready_after_reset", in_ready, 1);
      check("in_ready4_after_reset", in_ready4, 1);
      @(posedge clk);
      #1;

      // 3-word packet 1,3,7: parity 1^0^1 = 0, count 3, two cycles after the last accept
      n0 = log_q.size();
      push(32'h1, 1'b0);
      push(32'h3, 1'b0);
      push(32'h7, 1'b1);
      repeat (3) idle();
      check("t1_results", log_q.size() - n0, 1);
      if (log_q.size() > n0) begin
         check("t1_parity", log_q[n0].parity, 0);
         check("t1_count", log_q[n0].count, 3);
         check("t1_sat", log_q[n0].sat, 0);
         check("t1_latency", log_q[n0].cyc - last_acc_cyc, 2);
      end

      // Back-to-back single-word packets at full throughput
      n0 = log_q.size();
      push(32'hFFFF_FFFF, 1'b1);
      push(32'h8000_0000, 1'b1);
      push(32'h0000_0000, 1'b1);
      repeat (4) idle();
      check("t2_results", log_q.size() - n0, 3);
      if (log_q.size() >= n0 + 3) begin
         check("t2_parity0", log_q[n0].parity, 0);
         check("t2_parity1", log_q[n0 + 1].parity, 1);
         check("t2_parity2", log_q[n0 + 2].parity, 0);
         check("t2_count0", log_q[n0].count, 1);
         check("t2_count1", log_q[n0 + 1].count, 1);
         check("t2_count2", log_q[n0 + 2].count, 1);
         check("t2_gap01", log_q[n0 + 1].cyc - log_q[n0].cyc, 1);
         check("t2_gap12", log_q[n0 + 2].cyc - log_q[n0 + 1].cyc, 1);
      end

      // Output stall: result A held, packet B's non-last word flows, its last word sticks
      n0 = log_q.size();
      ready_force = 1'b0;
      push(32'h1, 1'b1);
      push(32'h3, 1'b0);
      push(32'h6, 1'b1);
      repeat (5) begin
         @(negedge clk);
         check("t3_hold_valid", out_valid, 1);
         check("t3_hold_parity", out_parity, 1);
         check("t3_hold_count", out_count, 1);
         check("t3_in_ready_low", in_ready, 0);
         @(posedge clk);
         #1;
      end
      ready_force = 1'b1;
      repeat (5) idle();
      check("t3_results", log_q.size() - n0, 2);
      if (log_q.size() >= n0 + 2) begin
         check("t3_a_parity", log_q[n0].parity, 1);
         check("t3_a_count", log_q[n0].count, 1);
         check("t3_b_parity", log_q[n0 + 1].parity, 0);
         check("t3_b_count", log_q[n0 + 1].count, 2);
      end

      // 20 words of 0x1: narrow counter saturates at 15, wide one reaches 20
      n0 = log_q.size();
      n4 = log4_q.size();
      for (int w = 0; w < 20; w++) push(32'h1, w == 19);
      repeat (4) idle();
      check("t4_results", log_q.size() - n0, 1);
      check("t4_results4", log4_q.size() - n4, 1);
      if (log_q.size() > n0) begin
         check("t4_count_wide", log_q[n0].count, 20);
         check("t4_sat_wide", log_q[n0].sat, 0);
         check("t4_parity_wide", log_q[n0].parity, 0);
      end
      if (log4_q.size() > n4) begin
         check("t4_parity4", log4_q[n4][5], 0);
         check("t4_count4", log4_q[n4][4:1], 15);
         check("t4_sat4", log4_q[n4][0], 1);
      end

      // Reset mid-packet discards the partial packet
      n0 = log_q.size();
      push(32'h5, 1'b0);
      push(32'h2, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("t5_in_ready_after_reset", in_ready, 1);
      check("t5_out_valid_after_reset", out_valid, 0);
      @(posedge clk);
      #1;
      push(32'h1, 1'b1);
      repeat (4) idle();
      check("t5_results", log_q.size() - n0, 1);
      if (log_q.size() > n0) begin
         check("t5_parity", log_q[n0].parity, 1);
         check("t5_count", log_q[n0].count, 1);
      end

      // Random traffic against the model
      n0 = log_q.size();
      rand_mode = 1'b1;
      for (int p = 0; p < NPKT; p++) begin
         len = $urandom_range(1, 3);
         if ($urandom_range(0, 49) == 0) len = $urandom_range(4, 12);
         for (int w = 0; w < len; w++) begin
            if ($urandom_range(0, 3) == 0) idle();
            push($urandom, w == len - 1);
         end
      end
      rand_mode = 1'b0;
      for (int g = 0; g < 100; g++) begin
         if (exp_q.size() == 0 && !out_valid) break;
         idle();
      end
      repeat (2) idle();
      check("rand_results", log_q.size() - n0, NPKT);
      check("drain_pending", exp_q.size(), 0);
      check("drain_out_valid", out_valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
